// File: rtl/lcdi_pkg.sv
// lcdi_pkg: shared constants and helpers for the gradient-class index pipeline.
package lcdi_pkg;
   localparam int NUM_CLASS = 9;
   localparam int CLS_W     = 4;

   // default thresholds for 8-bit samples, T0 < T1 < T2 < T3
   localparam int DEF_T0 = 4;
   localparam int DEF_T1 = 16;
   localparam int DEF_T2 = 32;
   localparam int DEF_T3 = 48;

   function automatic int pow9(input int k);
      int p = 1;
      for (int i = 0; i < k; i++) p = p * NUM_CLASS;
      return p;
   endfunction

   // bits needed to hold 9^num_diff-1: 4/7/10 for 1/2/3 differences
   function automatic int idx_width(input int num_diff);
      return $clog2(pow9(num_diff));
   endfunction
endpackage

// File: rtl/lcdi_grad_classify.sv
// lcdi_grad_classify: maps one signed neighbour difference onto one of nine
// gradient classes (0 = strongest positive, 4 = flat, 8 = strongest negative).
module lcdi_grad_classify
   import lcdi_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic signed [DATA_WIDTH:0]   diff,
   input  logic [3:0][DATA_WIDTH-1:0]   thresh,
   output logic [CLS_W-1:0]             cls
);
   // one spare bit so the negated thresholds never wrap
   localparam int CW = DATA_WIDTH + 2;

   logic signed [CW-1:0] d;
   logic signed [CW-1:0] pos [4];
   logic signed [CW-1:0] neg [4];

   // band compare from the top down; first hit wins
   always_comb begin
      d = {diff[DATA_WIDTH], diff};
      for (int i = 0; i < 4; i++) begin
         pos[i] = $signed({2'b00, thresh[i]});
         neg[i] = -pos[i];
      end
      cls = 4'd8;
      if      (d >= pos[3]) cls = 4'd0;
      else if (d >= pos[2]) cls = 4'd1;
      else if (d >= pos[1]) cls = 4'd2;
      else if (d >= pos[0]) cls = 4'd3;
      else if (d >= neg[0]) cls = 4'd4;
      else if (d >= neg[1]) cls = 4'd5;
      else if (d >= neg[2]) cls = 4'd6;
      else if (d >= neg[3]) cls = 4'd7;
   end
endmodule

// File: rtl/lcdi_grad_index.sv
// lcdi_grad_index: two-stage pipeline turning a centre sample and NUM_DIFF
// neighbours into a base-9 gradient class index, with valid/ready handshakes.
// Optional macro LCDI_PROG_THRESH_EN makes the four thresholds programmable.
module lcdi_grad_index
   import lcdi_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_DIFF   = 2,
   parameter int IDX_WIDTH  = 7
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           flush,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [DATA_WIDTH-1:0]          center_in,
   input  logic [NUM_DIFF*DATA_WIDTH-1:0] nbr_in,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [DATA_WIDTH-1:0]          center_out,
   output logic [NUM_DIFF*DATA_WIDTH-1:0] nbr_out,
   output logic [IDX_WIDTH-1:0]           index
`ifdef LCDI_PROG_THRESH_EN
   ,
   input  logic                           cfg_we,
   input  logic [4*DATA_WIDTH-1:0]        cfg_thresh,
   output logic                           cfg_err
`endif
);
   localparam int STAGES = 2;
   localparam int SH     = (DATA_WIDTH > 8) ? DATA_WIDTH - 8 : 0;
   localparam logic [3:0][DATA_WIDTH-1:0] DEF_THR = {
      DATA_WIDTH'(DEF_T3 << SH), DATA_WIDTH'(DEF_T2 << SH),
      DATA_WIDTH'(DEF_T1 << SH), DATA_WIDTH'(DEF_T0 << SH)};

   logic [3:0][DATA_WIDTH-1:0] thr;

`ifdef LCDI_PROG_THRESH_EN
   logic [3:0][DATA_WIDTH-1:0] cfg_t;
   logic                       cfg_ok;
   assign cfg_t = cfg_thresh;

   // a write is usable only if strictly increasing with a non-zero T0
   always_comb begin
      cfg_ok = (cfg_t[0] != '0) && (cfg_t[0] < cfg_t[1]) &&
               (cfg_t[1] < cfg_t[2]) && (cfg_t[2] < cfg_t[3]);
   end

   // threshold registers; bad writes leave the old set and raise cfg_err
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         thr     <= DEF_THR;
         cfg_err <= 1'b0;
      end else if (cfg_we) begin
         if (cfg_ok) begin
            thr     <= cfg_t;
            cfg_err <= 1'b0;
         end else begin
            cfg_err <= 1'b1;
         end
      end
   end
`else
   assign thr = DEF_THR;
`endif

   // handshake: stage 2 drains on out_ready, stage 1 moves when stage 2 can take it
   logic [STAGES:1] vld_pipe;
   logic            adv1, adv2, acc;

   assign adv2      = !vld_pipe[2] || out_ready;
   assign adv1      = !vld_pipe[1] || adv2;
   assign in_ready  = adv1 && !flush;
   assign acc       = in_valid && in_ready;
   assign out_valid = vld_pipe[2];

   // per-neighbour classification
   logic [NUM_DIFF-1:0][DATA_WIDTH-1:0] nbr_v;
   logic [NUM_DIFF-1:0][CLS_W-1:0]      cls_c;
   assign nbr_v = nbr_in;

   for (genvar k = 0; k < NUM_DIFF; k++) begin : g_lane
      logic signed [DATA_WIDTH:0] diff;
      assign diff = $signed({1'b0, nbr_v[k]}) - $signed({1'b0, center_in});
      lcdi_grad_classify #(.DATA_WIDTH(DATA_WIDTH)) u_cls (
         .diff   (diff),
         .thresh (thr),
         .cls    (cls_c[k])
      );
   end

   // stage 1 holding registers
   logic [DATA_WIDTH-1:0]          center1;
   logic [NUM_DIFF*DATA_WIDTH-1:0] nbr1;
   logic [NUM_DIFF-1:0][CLS_W-1:0] cls1;
   logic [IDX_WIDTH-1:0]           idx_c;

   // valid shift register; flush empties both stages
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe <= '0;
      end else if (flush) begin
         vld_pipe <= '0;
      end else begin
         if (adv1) vld_pipe[1] <= acc;
         if (adv2) vld_pipe[2] <= vld_pipe[1];
      end
   end

   // stage 1 data loads only on an accepted sample
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         center1 <= '0;
         nbr1    <= '0;
         cls1    <= '0;
      end else if (acc) begin
         center1 <= center_in;
         nbr1    <= nbr_in;
         cls1    <= cls_c;
      end
   end

   // base-9 index from the registered classes
   always_comb begin
      idx_c = '0;
      for (int k = 0; k < NUM_DIFF; k++)
         idx_c = idx_c + IDX_WIDTH'(cls1[k]) * IDX_WIDTH'(pow9(k));
   end

   // stage 2 data loads only when a valid stage 1 sample moves forward
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         center_out <= '0;
         nbr_out    <= '0;
         index      <= '0;
      end else if (!flush && adv2 && vld_pipe[1]) begin
         center_out <= center1;
         nbr_out    <= nbr1;
         index      <= idx_c;
      end
   end
endmodule

// File: tb/tb_lcdi_grad_index.sv
// tb_lcdi_grad_index: directed checks of the gradient index pipeline
// (default 8-bit / two-neighbour build).
module tb_lcdi_grad_index;
   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [7:0]  center_in, center_out;
   logic [15:0] nbr_in, nbr_out;
   logic [6:0]  index;
`ifdef LCDI_PROG_THRESH_EN
   logic        cfg_we, cfg_err;
   logic [31:0] cfg_thresh;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   lcdi_grad_index #(.DATA_WIDTH(8), .NUM_DIFF(2), .IDX_WIDTH(7)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .center_in  (center_in),
      .nbr_in     (nbr_in),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .center_out (center_out),
      .nbr_out    (nbr_out),
      .index      (index)
`ifdef LCDI_PROG_THRESH_EN
      ,
      .cfg_we     (cfg_we),
      .cfg_thresh (cfg_thresh),
      .cfg_err    (cfg_err)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      center_in = 8'd0; nbr_in = 16'd0;
`ifdef LCDI_PROG_THRESH_EN
      cfg_we = 1'b0; cfg_thresh = 32'd0;
`endif
      tick(); tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (index !== 7'd0) begin failures++; $display("FAIL reset_index got=%0d exp=0", index); end
      checks++; if (center_out !== 8'd0) begin failures++; $display("FAIL reset_center got=%0d exp=0", center_out); end
      checks++; if (nbr_out !== 16'd0) begin failures++; $display("FAIL reset_nbr got=%h exp=0000", nbr_out); end
`ifdef LCDI_PROG_THRESH_EN
      checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL reset_cfg_err got=%b exp=0", cfg_err); end
`endif
      rst = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_basic();
      center_in = 8'd100; nbr_in = {8'd100, 8'd160}; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b exp=0", out_valid); end
      tick();
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
      checks++; if (index !== 7'd36) begin failures++; $display("FAIL basic_index got=%0d exp=36", index); end
      checks++; if (center_out !== 8'd100) begin failures++; $display("FAIL basic_center got=%0d exp=100", center_out); end
      checks++; if (nbr_out !== 16'h64A0) begin failures++; $display("FAIL basic_nbr got=%h exp=64a0", nbr_out); end
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_dup got=%b exp=0", out_valid); end
   endtask

   task automatic test_sweep();
      logic [7:0] sc  [11] = '{8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100,
                              8'd100, 8'd100, 8'd100, 8'd100, 8'd255};
      logic [7:0] sn0 [11] = '{8'd148, 8'd147, 8'd116, 8'd115, 8'd104, 8'd103,
                              8'd96, 8'd95, 8'd52, 8'd51, 8'd0};
      logic [7:0] sn1 [11] = '{8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100,
                              8'd100, 8'd100, 8'd100, 8'd100, 8'd0};
      logic [6:0] ex  [11] = '{7'd36, 7'd37, 7'd38, 7'd39, 7'd39, 7'd40,
                              7'd40, 7'd41, 7'd43, 7'd44, 7'd80};
      int i = 0, o = 0;
      logic rdy;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 40 && o < 11; cyc++) begin
         in_valid = (i < 11);
         if (i < 11) begin center_in = sc[i]; nbr_in = {sn1[i], sn0[i]}; end
         #1;
         rdy = in_ready;
         if (out_valid) begin
            checks++; if (index !== ex[o]) begin failures++; $display("FAIL sweep_index[%0d] got=%0d exp=%0d", o, index, ex[o]); end
            checks++; if (center_out !== sc[o]) begin failures++; $display("FAIL sweep_center[%0d] got=%0d exp=%0d", o, center_out, sc[o]); end
            checks++; if (nbr_out !== {sn1[o], sn0[o]}) begin failures++; $display("FAIL sweep_nbr[%0d] got=%h exp=%h", o, nbr_out, {sn1[o], sn0[o]}); end
            o++;
         end
         @(posedge clk);
         if (rdy && in_valid) i++;
         #1;
      end
      in_valid = 1'b0;
      checks++; if (o != 11) begin failures++; $display("FAIL sweep_count got=%0d exp=11", o); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] sc  [4] = '{8'd50, 8'd60, 8'd70, 8'd80};
      logic [7:0] sn0 [4] = '{8'd100, 8'd70, 8'd70, 8'd60};
      logic [7:0] sn1 [4] = '{8'd50, 8'd60, 8'd40, 8'd200};
      logic [6:0] ex  [4] = '{7'd36, 7'd39, 7'd58, 7'd6};
      logic       er  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      int i = 0, o = 0;
      logic rdy;
      // stalled output: two samples fill the pipe, then input stops
      out_ready = 1'b0;
      for (int cyc = 0; cyc < 5; cyc++) begin
         in_valid = (i < 4);
         if (i < 4) begin center_in = sc[i]; nbr_in = {sn1[i], sn0[i]}; end
         #1;
         rdy = in_ready;
         checks++; if (rdy !== er[cyc]) begin failures++; $display("FAIL stall_in_ready[%0d] got=%b exp=%b", cyc, rdy, er[cyc]); end
         if (cyc >= 2) begin
            checks++; if (out_valid !== 1'b1 || index !== 7'd36 || center_out !== 8'd50 || nbr_out !== 16'h3264) begin
               failures++; $display("FAIL stall_hold[%0d] got=%b/%0d/%0d/%h exp=1/36/50/3264", cyc, out_valid, index, center_out, nbr_out);
            end
         end
         @(posedge clk);
         if (rdy && in_valid) i++;
         #1;
      end
      checks++; if (i != 2) begin failures++; $display("FAIL stall_accepts got=%0d exp=2", i); end
      // release and drain in order
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 20 && o < 4; cyc++) begin
         in_valid = (i < 4);
         if (i < 4) begin center_in = sc[i]; nbr_in = {sn1[i], sn0[i]}; end
         #1;
         rdy = in_ready;
         if (out_valid) begin
            checks++; if (index !== ex[o] || center_out !== sc[o] || nbr_out !== {sn1[o], sn0[o]}) begin
               failures++; $display("FAIL drain[%0d] got=%0d/%0d/%h exp=%0d/%0d/%h", o, index, center_out, nbr_out, ex[o], sc[o], {sn1[o], sn0[o]});
            end
            o++;
         end
         @(posedge clk);
         if (rdy && in_valid) i++;
         #1;
      end
      in_valid = 1'b0;
      checks++; if (o != 4) begin failures++; $display("FAIL drain_count got=%0d exp=4", o); end
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_extra got=%b exp=0", out_valid); end
   endtask

   task automatic test_reset_midflight();
      logic seen = 1'b0;
      out_ready = 1'b0;
      center_in = 8'd50; nbr_in = {8'd50, 8'd100}; in_valid = 1'b1;
      tick();
      center_in = 8'd60; nbr_in = {8'd60, 8'd70};
      tick();
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b exp=0", out_valid); end
      checks++; if (index !== 7'd0) begin failures++; $display("FAIL rst_mid_index got=%0d exp=0", index); end
      checks++; if (center_out !== 8'd0) begin failures++; $display("FAIL rst_mid_center got=%0d exp=0", center_out); end
      tick();
      rst = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_in_ready got=%b exp=1", in_ready); end
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (out_valid !== 1'b0) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rst_mid_emitted got=%b exp=0", seen); end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      center_in = 8'd70; nbr_in = {8'd40, 8'd70}; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b1 || index !== 7'd58) begin failures++; $display("FAIL flush_setup got=%b/%0d exp=1/58", out_valid, index); end
      flush = 1'b1; in_valid = 1'b1; center_in = 8'd80; nbr_in = {8'd200, 8'd60};
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
      out_ready = 1'b1;
      tick(); tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_leak got=%b exp=0", out_valid); end
   endtask

`ifdef LCDI_PROG_THRESH_EN
   task automatic test_cfg();
      out_ready = 1'b1;
      cfg_thresh = {8'd24, 8'd16, 8'd8, 8'd2}; cfg_we = 1'b1;
      tick();
      cfg_we = 1'b0;
      checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL cfg_good_err got=%b exp=0", cfg_err); end
      center_in = 8'd100; nbr_in = {8'd100, 8'd120}; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b1 || index !== 7'd37) begin failures++; $display("FAIL cfg_good_index got=%b/%0d exp=1/37", out_valid, index); end
      tick();
      cfg_thresh = {8'd24, 8'd16, 8'd4, 8'd8}; cfg_we = 1'b1;
      tick();
      cfg_we = 1'b0;
      checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL cfg_bad_err got=%b exp=1", cfg_err); end
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b1 || index !== 7'd37) begin failures++; $display("FAIL cfg_bad_index got=%b/%0d exp=1/37", out_valid, index); end
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_sweep();
      test_back_to_back();
      test_reset_midflight();
      test_flush();
`ifdef LCDI_PROG_THRESH_EN
      test_cfg();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
